// File: rtl/push_source_pkg.sv
// Shared types and widths for the push_source transmit block.
package push_source_pkg;

  localparam int unsigned COUNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PUSH = 2'd1,
    GAP  = 2'd2
  } push_state_e;

endpackage

// File: rtl/push_source_fifo.sv
// Synchronous FIFO holding values waiting to be pushed; head is read combinationally.
module push_source_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/push_source.sv
// Buffers producer loads and emits them as single-cycle pushes with programmable idle spacing.
module push_source
  import push_source_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned GAP_WIDTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic [GAP_WIDTH-1:0]   gap_i,
  input  logic                   load_valid_i,
  input  logic [DATA_WIDTH-1:0]  load_data_i,
  output logic                   load_ready_o,
  output logic                   push_valid_o,
  output logic [DATA_WIDTH-1:0]  push_data_o,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   idle_o
);

  push_state_e            state_q, state_d;
  logic [GAP_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
  logic                   push_valid_q, push_valid_d;
  logic [DATA_WIDTH-1:0]  push_data_q, push_data_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  wr_en;
  logic                  pop;
  logic                  pop_ok;

  assign wr_en  = load_valid_i && !fifo_full;
  assign pop_ok = enable_i && !fifo_empty;

  push_source_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .wr_en_i   (wr_en),
    .wr_data_i (load_data_i),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
      push_valid_q <= 1'b0;
      push_data_q  <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      push_valid_q <= push_valid_d;
      push_data_q  <= push_data_d;
      count_q      <= count_d;
    end
  end

  // Pacing FSM: gap is captured once on leaving PUSH; a pending pop always waits for enable.
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    push_valid_d = 1'b0;
    push_data_d  = push_data_q;
    count_d      = count_q;
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (pop_ok) pop = 1'b1;
      end
      PUSH: begin
        if (gap_i != '0) begin
          state_d   = GAP;
          gap_cnt_d = gap_i;
        end else if (pop_ok) begin
          pop = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_q > GAP_WIDTH'(1)) begin
          gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
        end else if (pop_ok) begin
          pop = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      state_d      = PUSH;
      push_valid_d = 1'b1;
      push_data_d  = fifo_head;
      count_d      = count_q + COUNT_WIDTH'(1);
    end
  end

  assign load_ready_o = !fifo_full;
  assign push_valid_o = push_valid_q;
  assign push_data_o  = push_data_q;
  assign count_o      = count_q;
  assign idle_o       = fifo_empty && (state_q == IDLE) && !push_valid_q;

endmodule

// File: tb/tb_push_source.sv
// Bench for push_source paired with a sampling receiver; reference model tracks a queue and push timing.
module tb_push_source;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned GW    = 4;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [GW-1:0] gap;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          push_valid;
  logic [DW-1:0] push_data;
  logic [15:0]   count;
  logic          idle;
  logic [DW-1:0] rx_sampled;

  int total = 0;
  int bad   = 0;

  push_source #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP_WIDTH(GW)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .enable_i     (enable),
    .gap_i        (gap),
    .load_valid_i (load_valid),
    .load_data_i  (load_data),
    .load_ready_o (load_ready),
    .push_valid_o (push_valid),
    .push_data_o  (push_data),
    .count_o      (count),
    .idle_o       (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (reset) rx_sampled <= '0;
    else if (push_valid) rx_sampled <= push_data;
  end

  // Model: a push may start at edge t when enabled, data is queued, and t >= last_push + 1 + gap,
  // where gap is the value seen on the edge right after the previous push.
  logic [DW-1:0] mq [$];
  int            cyc    = 0;
  int            m_last = -1000;
  int            m_gap  = 0;
  logic          m_pv   = 1'b0;
  logic [DW-1:0] m_pd   = '0;
  logic [15:0]   m_cnt  = '0;
  logic          m_rdy  = 1'b1;
  logic          m_idle = 1'b1;

  task automatic tick();
    int  ge;
    bit  acc;
    cyc++;
    if (reset) begin
      mq.delete();
      m_pv = 1'b0; m_pd = '0; m_cnt = '0; m_last = -1000; m_gap = 0;
    end else begin
      ge = (cyc == m_last + 1) ? int'(gap) : m_gap;
      if (cyc == m_last + 1) m_gap = int'(gap);
      acc = load_valid && (mq.size() < DEPTH);
      if (enable && (mq.size() > 0) && (cyc >= m_last + 1 + ge)) begin
        m_pv = 1'b1; m_pd = mq.pop_front(); m_cnt = m_cnt + 16'd1; m_last = cyc;
      end else begin
        m_pv = 1'b0;
      end
      if (acc) mq.push_back(load_data);
    end
    m_rdy  = (mq.size() < DEPTH);
    m_idle = (mq.size() == 0) && !m_pv && !((m_gap > 0) && (cyc >= m_last + 1) && (cyc <= m_last + m_gap));
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [26:0] dut_vec();
    return {push_valid, push_data, count, load_ready, idle};
  endfunction

  function automatic logic [26:0] exp_vec();
    return {m_pv, m_pd, m_cnt, m_rdy, m_idle};
  endfunction

  task automatic do_reset();
    reset = 1'b1; load_valid = 1'b0; load_data = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; gap = '0; load_valid = 1'b0; load_data = '0;
    tick(); tick();
    total++;
    if ({push_valid, push_data, count, idle} !== {1'b0, 8'h00, 16'h0000, 1'b1}) begin
      bad++; $display("FAIL reset_state got pv=%b pd=%h cnt=%h idle=%b want 0 00 0000 1", push_valid, push_data, count, idle);
    end
    reset = 1'b0;
    tick();
    total++;
    if (load_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready got %b want 1", load_ready);
    end
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_model cyc=%0d got %h want %h", cyc, dut_vec(), exp_vec());
    end
  endtask

  task automatic test_single();
    do_reset();
    gap = '0; enable = 1'b1;
    load_valid = 1'b1; load_data = 8'hA5;
    tick();
    load_valid = 1'b0;
    total++;
    if (push_valid !== 1'b0) begin
      bad++; $display("FAIL single_no_fallthrough got pv=%b want 0", push_valid);
    end
    tick();
    total++;
    if ({push_valid, push_data} !== {1'b1, 8'hA5}) begin
      bad++; $display("FAIL single_push got pv=%b pd=%h want 1 a5", push_valid, push_data);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL single_model cyc=%0d got %h want %h", cyc, dut_vec(), exp_vec());
      end
    end
    total++;
    if ({rx_sampled, count, idle, push_valid} !== {8'hA5, 16'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL single_after got rx=%h cnt=%0d idle=%b pv=%b want a5 1 1 0", rx_sampled, count, idle, push_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] seen [$];
    int            pc   [$];
    do_reset();
    gap = '0; enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      load_valid = (i < 4);
      load_data  = DW'(i + 1);
      tick();
      if (push_valid) begin seen.push_back(push_data); pc.push_back(cyc); end
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL b2b_model cyc=%0d got %h want %h", cyc, dut_vec(), exp_vec());
      end
    end
    load_valid = 1'b0;
    total++;
    if (seen.size() != 4 || pc.size() != 4) begin
      bad++; $display("FAIL b2b_num got %0d pushes want 4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (seen[i] !== DW'(i + 1)) begin
          bad++; $display("FAIL b2b_order idx=%0d got %h want %h", i, seen[i], DW'(i + 1));
        end
      end
      total++;
      if (pc[3] - pc[0] != 3) begin
        bad++; $display("FAIL b2b_span got %0d want 3", pc[3] - pc[0]);
      end
    end
    total++;
    if ({count, rx_sampled} !== {16'd4, 8'h04}) begin
      bad++; $display("FAIL b2b_final got cnt=%0d rx=%h want 4 04", count, rx_sampled);
    end
  endtask

  task automatic test_gap();
    int pc [$];
    do_reset();
    gap = 4'd3; enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load_valid = (i < 2);
      load_data  = (i == 0) ? 8'h10 : 8'h20;
      tick();
      if (push_valid) pc.push_back(cyc);
      if (pc.size() == 1 && cyc == pc[0] + 1) gap = '0;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL gap_model cyc=%0d got %h want %h", cyc, dut_vec(), exp_vec());
      end
    end
    load_valid = 1'b0;
    total++;
    if (pc.size() != 2) begin
      bad++; $display("FAIL gap_num got %0d pushes want 2", pc.size());
    end else if (pc[1] - pc[0] != 4) begin
      bad++; $display("FAIL gap_spacing got %0d idle cycles want 3", pc[1] - pc[0] - 1);
    end
  endtask

  task automatic test_enable_hold();
    logic [DW-1:0] seen [$];
    int            first_pop = -1;
    int            acc_cyc   = -1;
    bit            will_acc;
    do_reset();
    gap = '0; enable = 1'b0;
    for (int v = 1; v <= 4; v++) begin
      load_valid = 1'b1; load_data = DW'(v);
      tick();
    end
    total++;
    if (load_ready !== 1'b0) begin
      bad++; $display("FAIL hold_full got ready=%b want 0", load_ready);
    end
    load_data = 8'h05;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({load_ready, push_valid} !== 2'b00) begin
        bad++; $display("FAIL hold_wait got ready=%b pv=%b want 0 0", load_ready, push_valid);
      end
    end
    enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      will_acc = load_valid && load_ready;
      tick();
      if (will_acc) begin acc_cyc = cyc; load_valid = 1'b0; end
      if (push_valid) begin
        seen.push_back(push_data);
        if (first_pop < 0) first_pop = cyc;
      end
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL hold_model cyc=%0d got %h want %h", cyc, dut_vec(), exp_vec());
      end
    end
    load_valid = 1'b0;
    total++;
    if (acc_cyc != first_pop + 1) begin
      bad++; $display("FAIL hold_accept got cyc=%0d want %0d", acc_cyc, first_pop + 1);
    end
    total++;
    if (seen.size() != 5) begin
      bad++; $display("FAIL hold_num got %0d pushes want 5", seen.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (seen[i] !== DW'(i + 1)) begin
          bad++; $display("FAIL hold_order idx=%0d got %h want %h", i, seen[i], DW'(i + 1));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int pushes = 0;
    do_reset();
    gap = '0; enable = 1'b0;
    load_valid = 1'b1; load_data = 8'h33; tick();
    load_data = 8'h44; tick();
    load_valid = 1'b0; enable = 1'b1;
    tick();
    total++;
    if ({push_valid, push_data} !== {1'b1, 8'h33}) begin
      bad++; $display("FAIL rmid_push got pv=%b pd=%h want 1 33", push_valid, push_data);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if ({push_valid, count, idle} !== {1'b0, 16'd0, 1'b1}) begin
      bad++; $display("FAIL rmid_reset got pv=%b cnt=%0d idle=%b want 0 0 1", push_valid, count, idle);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      if (push_valid) pushes++;
    end
    total++;
    if (pushes != 0 || dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL rmid_after got pushes=%0d vec=%h want 0 %h", pushes, dut_vec(), exp_vec());
    end
  endtask

  task automatic test_enable_gap();
    int pushes = 0;
    do_reset();
    gap = 4'd2; enable = 1'b1;
    load_valid = 1'b1; load_data = 8'h55; tick();
    load_data = 8'h66; tick();
    load_valid = 1'b0;
    total++;
    if ({push_valid, push_data} !== {1'b1, 8'h55}) begin
      bad++; $display("FAIL engap_first got pv=%b pd=%h want 1 55", push_valid, push_data);
    end
    tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (push_valid) pushes++;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL engap_model cyc=%0d got %h want %h", cyc, dut_vec(), exp_vec());
      end
    end
    total++;
    if (pushes != 0) begin
      bad++; $display("FAIL engap_held got %0d pushes want 0", pushes);
    end
    enable = 1'b1;
    tick();
    total++;
    if ({push_valid, push_data} !== {1'b1, 8'h66}) begin
      bad++; $display("FAIL engap_resume got pv=%b pd=%h want 1 66", push_valid, push_data);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      load_valid = 1'($urandom_range(0, 1));
      load_data  = DW'($urandom);
      enable     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) gap = GW'($urandom_range(0, 4));
      reset      = ($urandom_range(0, 199) == 0);
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_model cyc=%0d got %h want %h", cyc, dut_vec(), exp_vec());
      end
    end
    reset = 1'b0; load_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; gap = '0; load_valid = 1'b0; load_data = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_enable_hold();
    test_reset_mid();
    test_enable_gap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
